// File: rtl/inverse_transpose_scheduler.sv
// inverse_transpose_scheduler
// Two-slot ping-pong buffer between the upscaling pipeline and the output row
// writer. Each accepted chunk is read back through an inverse chunk transposer.
// Its CELL_SIZE video rows leave one beat at a time. Every beat is tagged with
// its output line and chunk column. A chunk carrying an SOF tag forces its
// beats to position (0,0) and restarts the frame counters from there.

// Inverse chunk transposer: video row r collects row r of every cell in order.
module inverse_chunk_transposer #(
  parameter int CELL_SIZE  = 2,
  parameter int CHUNK_SIZE = 64,
  parameter int PIX_W      = 8
) (
  input  logic [CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0][PIX_W-1:0] chunk_in,
  output logic [CELL_SIZE-1:0][CHUNK_SIZE-1:0][CELL_SIZE-1:0][PIX_W-1:0] video_out
);

  // Swap the cell and row dimensions so that each video row is contiguous.
  always_comb begin
    video_out = '0;
    for (int r = 0; r < CELL_SIZE; r++) begin
      for (int j = 0; j < CHUNK_SIZE; j++) begin
        video_out[r][j] = chunk_in[j][r];
      end
    end
  end

endmodule

module inverse_transpose_scheduler #(
  parameter int CELL_SIZE       = 2,
  parameter int CHUNK_SIZE      = 64,
  parameter int CHUNKS_PER_LINE = 10,
  parameter int CHUNK_LINES     = 360,
  parameter int PIX_W           = 8
) (
  input  logic                                                           clk,
  input  logic                                                           reset,
  input  logic                                                           in_valid,
  output logic                                                           in_ready,
  input  logic                                                           in_sof,
  input  logic [CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0][PIX_W-1:0] in_chunk,
  output logic                                                           row_valid,
  input  logic                                                           row_ready,
  output logic [CHUNK_SIZE-1:0][CELL_SIZE-1:0][PIX_W-1:0]                row_data,
  output logic [$clog2(CHUNK_LINES*CELL_SIZE)-1:0]                       row_line,
  output logic [$clog2(CHUNKS_PER_LINE)-1:0]                             row_col,
  output logic                                                           row_eol,
  output logic                                                           row_eof,
  output logic                                                           frame_done
);

  localparam int R_W    = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
  localparam int COL_W  = $clog2(CHUNKS_PER_LINE);
  localparam int LINE_W = $clog2(CHUNK_LINES);
  localparam int ROWL_W = $clog2(CHUNK_LINES*CELL_SIZE);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(CHUNKS_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(CHUNK_LINES - 1);
  localparam logic [R_W-1:0]    R_LAST    = R_W'(CELL_SIZE - 1);

  typedef logic [CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0][PIX_W-1:0] chunk_t;
  typedef logic [CELL_SIZE-1:0][CHUNK_SIZE-1:0][CELL_SIZE-1:0][PIX_W-1:0] video_t;

  // Buffer state
  chunk_t            slot_q [2];
  chunk_t            slot_d [2];
  logic [1:0]        sof_q, sof_d;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;

  // Frame position state
  logic [R_W-1:0]    r_q, r_d;
  logic [COL_W-1:0]  chunk_col_q, chunk_col_d;
  logic [LINE_W-1:0] chunk_line_q, chunk_line_d;
  logic              frame_done_q, frame_done_d;

  // Combinational helpers
  logic              push_s;
  logic              fire_s;
  logic              pop_s;
  logic              head_sof_s;
  logic [COL_W-1:0]  eff_col_s;
  logic [LINE_W-1:0] eff_line_s;
  video_t            video_s;

  assign in_ready   = (count_q < 2'd2);
  assign row_valid  = (count_q != 2'd0);
  assign push_s     = in_valid & in_ready;
  assign fire_s     = row_valid & row_ready;
  assign pop_s      = fire_s & (r_q == R_LAST);

  // An SOF-tagged head chunk sits at (0,0) whatever the counters say.
  assign head_sof_s = sof_q[rd_ptr_q];
  assign eff_col_s  = head_sof_s ? {COL_W{1'b0}}  : chunk_col_q;
  assign eff_line_s = head_sof_s ? {LINE_W{1'b0}} : chunk_line_q;

  inverse_chunk_transposer #(
    .CELL_SIZE  (CELL_SIZE),
    .CHUNK_SIZE (CHUNK_SIZE),
    .PIX_W      (PIX_W)
  ) u_transposer (
    .chunk_in  (slot_q[rd_ptr_q]),
    .video_out (video_s)
  );

  assign row_data   = video_s[r_q];
  assign row_line   = ROWL_W'(eff_line_s) * ROWL_W'(CELL_SIZE) + ROWL_W'(r_q);
  assign row_col    = eff_col_s;
  assign row_eol    = (eff_col_s == COL_LAST);
  assign row_eof    = row_eol & (eff_line_s == LINE_LAST) & (r_q == R_LAST);
  assign frame_done = frame_done_q;

  // Next-state: slot writes, pointer and occupancy updates, row and position stepping.
  always_comb begin
    slot_d       = slot_q;
    sof_d        = sof_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    r_d          = r_q;
    chunk_col_d  = chunk_col_q;
    chunk_line_d = chunk_line_q;
    frame_done_d = fire_s & row_eof;

    if (push_s) begin
      slot_d[wr_ptr_q] = in_chunk;
      sof_d[wr_ptr_q]  = in_sof;
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      r_d      = {R_W{1'b0}};
      rd_ptr_d = ~rd_ptr_q;
      // Advance from the position the head chunk actually used.
      if (eff_col_s == COL_LAST) begin
        chunk_col_d = {COL_W{1'b0}};
        if (eff_line_s == LINE_LAST) begin
          chunk_line_d = {LINE_W{1'b0}};
        end else begin
          chunk_line_d = eff_line_s + {{(LINE_W-1){1'b0}}, 1'b1};
        end
      end else begin
        chunk_col_d  = eff_col_s + {{(COL_W-1){1'b0}}, 1'b1};
        chunk_line_d = eff_line_s;
      end
    end else if (fire_s) begin
      r_d = r_q + {{(R_W-1){1'b0}}, 1'b1};
    end else begin
      r_d = r_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous reset clearing slots, tags and position.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q[0]    <= '0;
      slot_q[1]    <= '0;
      sof_q        <= 2'b00;
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      r_q          <= {R_W{1'b0}};
      chunk_col_q  <= {COL_W{1'b0}};
      chunk_line_q <= {LINE_W{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      slot_q[0]    <= slot_d[0];
      slot_q[1]    <= slot_d[1];
      sof_q        <= sof_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      r_q          <= r_d;
      chunk_col_q  <= chunk_col_d;
      chunk_line_q <= chunk_line_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_inverse_transpose_scheduler.sv
// Testbench for inverse_transpose_scheduler: random chunks and random flow
// control against a reference model that numbers chunks within the frame.
module tb_inverse_transpose_scheduler;

  localparam int CS  = 2;
  localparam int CK  = 64;
  localparam int CPL = 10;
  localparam int CL  = 360;
  localparam int PW  = 8;
  localparam int FRAME_CHUNKS = CPL * CL;

  typedef logic [CK-1:0][CS-1:0][CS-1:0][PW-1:0] chunk_t;
  typedef logic [CK-1:0][CS-1:0][PW-1:0]         row_t;
  typedef struct packed {
    row_t       data;
    logic [9:0] line;
    logic [3:0] col;
    logic       eol;
    logic       eof;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, in_sof;
  logic       row_valid, row_ready, row_eol, row_eof, frame_done;
  chunk_t     in_chunk;
  row_t       row_data;
  logic [9:0] row_line;
  logic [3:0] row_col;

  always #5 clk = ~clk;

  inverse_transpose_scheduler #(
    .CELL_SIZE(CS), .CHUNK_SIZE(CK), .CHUNKS_PER_LINE(CPL), .CHUNK_LINES(CL), .PIX_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_chunk(in_chunk), .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_line(row_line), .row_col(row_col), .row_eol(row_eol), .row_eof(row_eof),
    .frame_done(frame_done)
  );

  int    n_cmp = 0;
  int    n_fail = 0;
  beat_t exp_q[$];
  int    frame_pos;

  // Per-cycle observations, sampled on the falling edge.
  beat_t obs;
  logic  did_push, did_fire, obs_valid, obs_ready, obs_done;

  function automatic chunk_t rand_chunk();
    logic [CK*CS*CS*PW-1:0] flat;
    for (int k = 0; k < (CK*CS*CS*PW)/32; k++) flat[k*32 +: 32] = $urandom;
    return chunk_t'(flat);
  endfunction

  // Video row r: pixel x of cell j's row r, cells laid out left to right.
  function automatic row_t video_row(chunk_t c, int r);
    row_t v;
    for (int j = 0; j < CK; j++)
      for (int x = 0; x < CS; x++)
        v[j][x] = c[j][r][x];
    return v;
  endfunction

  // Reference model: chunk number within frame gives column and chunk-line.
  task automatic model_push(chunk_t c, logic sof);
    int pos;
    beat_t b;
    pos = sof ? 0 : frame_pos;
    for (int r = 0; r < CS; r++) begin
      b.data = video_row(c, r);
      b.line = 10'((pos / CPL) * CS + r);
      b.col  = 4'(pos % CPL);
      b.eol  = ((pos % CPL) == CPL - 1);
      b.eof  = (pos == FRAME_CHUNKS - 1) && (r == CS - 1);
      exp_q.push_back(b);
    end
    frame_pos = (pos + 1) % FRAME_CHUNKS;
  endtask

  task automatic step();
    @(negedge clk);
    did_push  = in_valid && in_ready;
    did_fire  = row_valid && row_ready;
    obs_valid = row_valid;
    obs_ready = in_ready;
    obs_done  = frame_done;
    obs       = {row_data, row_line, row_col, row_eol, row_eof};
    if (did_push) model_push(in_chunk, in_sof);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; row_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    frame_pos = 0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", obs_ready); end
    n_cmp++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_row_valid: got %b required 0", obs_valid); end
    n_cmp++; if (obs !== '0) begin n_fail++; $display("FAIL reset_tags: got line=%0d col=%0d eol=%b eof=%b required all 0", obs.line, obs.col, obs.eol, obs.eof); end
    n_cmp++; if (obs_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b required 0", obs_done); end
  endtask

  task automatic test_single_chunk();
    int fires = 0;
    beat_t e;
    do_reset();
    in_chunk = rand_chunk(); in_valid = 1'b1; row_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) begin
        n_cmp++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: row_valid got %b required 1", obs_valid); end
      end
      if (did_fire) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL single_extra_beat: got line=%0d required no beat", obs.line); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin n_fail++; $display("FAIL single_beat%0d: got line=%0d col=%0d data=%h required line=%0d col=%0d data=%h", fires, obs.line, obs.col, 64'(obs.data), e.line, e.col, 64'(e.data)); end
        end
        if (fires < 2) begin
          n_cmp++; if (obs.line !== 10'(fires)) begin n_fail++; $display("FAIL single_line: got %0d required %0d", obs.line, fires); end
        end
        fires++;
      end
    end
    n_cmp++; if (fires !== 2) begin n_fail++; $display("FAIL single_beat_count: got %0d required 2", fires); end
  endtask

  task automatic test_backpressure();
    chunk_t c[3];
    beat_t held, e;
    int acc = 0, fires = 0, gaps = 0;
    do_reset();
    for (int k = 0; k < 3; k++) c[k] = rand_chunk();
    row_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_chunk = c[(acc < 3) ? acc : 2];
      step();
      if (did_push) acc++;
      if (i == 1) held = obs;
      if (i >= 2) begin
        n_cmp++; if (obs !== held) begin n_fail++; $display("FAIL hold_stable: got line=%0d data=%h required line=%0d data=%h", obs.line, 64'(obs.data), held.line, 64'(held.data)); end
      end
    end
    n_cmp++; if (acc !== 2) begin n_fail++; $display("FAIL hold_accepts: got %0d required 2", acc); end
    n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready: got %b required 0", obs_ready); end
    row_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (did_push) begin acc++; in_valid = 1'b0; end
      if (!did_fire) gaps++;
      else begin
        fires++;
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL drain_extra_beat: got line=%0d required no beat", obs.line); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin n_fail++; $display("FAIL drain_beat: got line=%0d data=%h required line=%0d data=%h", obs.line, 64'(obs.data), e.line, 64'(e.data)); end
        end
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (fires !== 6 || gaps !== 0) begin n_fail++; $display("FAIL drain_no_gap: got %0d beats %0d gaps required 6 beats 0 gaps", fires, gaps); end
    n_cmp++; if (acc !== 3) begin n_fail++; $display("FAIL drain_third_accept: got %0d required 3", acc); end
  endtask

  task automatic test_line_wrap();
    int pushes = 0, beats = 0, cyc = 0;
    beat_t e;
    do_reset();
    while ((pushes < 11 || exp_q.size() != 0) && cyc < 400) begin
      in_valid  = (pushes < 11) && ($urandom_range(3, 0) != 0);
      in_chunk  = rand_chunk();
      row_ready = ($urandom_range(3, 0) != 0);
      step();
      cyc++;
      if (did_push) pushes++;
      if (did_fire) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL wrap_extra_beat: got line=%0d required no beat", obs.line); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin n_fail++; $display("FAIL wrap_beat%0d: got line=%0d col=%0d eol=%b required line=%0d col=%0d eol=%b", beats, obs.line, obs.col, obs.eol, e.line, e.col, e.eol); end
        end
        if (beats == 18 || beats == 19) begin
          n_cmp++; if (obs.col !== 4'd9 || obs.eol !== 1'b1) begin n_fail++; $display("FAIL wrap_col9: got col=%0d eol=%b required col=9 eol=1", obs.col, obs.eol); end
        end
        if (beats == 20) begin
          n_cmp++; if (obs.col !== 4'd0 || obs.line !== 10'd2) begin n_fail++; $display("FAIL wrap_next_line: got col=%0d line=%0d required col=0 line=2", obs.col, obs.line); end
        end
        beats++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (beats !== 22) begin n_fail++; $display("FAIL wrap_beat_count: got %0d required 22 (cycles used %0d)", beats, cyc); end
  endtask

  task automatic test_full_frame();
    int pushes = 0, beats = 0, cyc = 0, gaps = 0, eofs = 0, dones = 0, bad_done = 0;
    logic prev_eof = 1'b0;
    beat_t e;
    do_reset();
    while ((pushes < FRAME_CHUNKS + 1 || exp_q.size() != 0) && cyc < 40000) begin
      if (cyc < 400) begin
        in_valid = 1'b1; row_ready = 1'b1;
      end else begin
        in_valid  = ($urandom_range(7, 0) != 0);
        row_ready = ($urandom_range(7, 0) != 0);
      end
      if (pushes >= FRAME_CHUNKS + 1) in_valid = 1'b0;
      in_chunk = rand_chunk();
      step();
      if (did_push) pushes++;
      if (cyc >= 1 && cyc < 400 && !did_fire) gaps++;
      if (obs_done) begin dones++; if (!prev_eof) bad_done++; end
      prev_eof = did_fire && obs.eof;
      cyc++;
      if (did_fire) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL frame_extra_beat: got line=%0d required no beat", obs.line); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin n_fail++; $display("FAIL frame_beat%0d: got line=%0d col=%0d eof=%b required line=%0d col=%0d eof=%b", beats, obs.line, obs.col, obs.eof, e.line, e.col, e.eof); end
        end
        if (obs.eof) begin
          eofs++;
          n_cmp++; if (beats !== 2*FRAME_CHUNKS - 1 || obs.line !== 10'd719 || obs.col !== 4'd9) begin n_fail++; $display("FAIL frame_eof_place: got beat %0d line=%0d col=%0d required beat %0d line=719 col=9", beats, obs.line, obs.col, 2*FRAME_CHUNKS - 1); end
        end
        if (beats == 2*FRAME_CHUNKS) begin
          n_cmp++; if (obs.line !== 10'd0 || obs.col !== 4'd0) begin n_fail++; $display("FAIL frame_wrap: got line=%0d col=%0d required 0 0", obs.line, obs.col); end
        end
        beats++;
      end
    end
    step();
    if (obs_done) begin dones++; if (!prev_eof) bad_done++; end
    n_cmp++; if (gaps !== 0) begin n_fail++; $display("FAIL frame_throughput: got %0d gaps required 0", gaps); end
    n_cmp++; if (eofs !== 1) begin n_fail++; $display("FAIL frame_eof_count: got %0d required 1", eofs); end
    n_cmp++; if (dones !== 1 || bad_done !== 0) begin n_fail++; $display("FAIL frame_done_pulse: got %0d pulses %0d misplaced required 1 0", dones, bad_done); end
    n_cmp++; if (beats !== 2*(FRAME_CHUNKS + 1)) begin n_fail++; $display("FAIL frame_beat_count: got %0d required %0d (cycles %0d)", beats, 2*(FRAME_CHUNKS + 1), cyc); end
  endtask

  task automatic test_sof_resync();
    int pushes = 0, beats = 0, cyc = 0, eofs = 0, dones = 0;
    beat_t e;
    do_reset();
    while ((pushes < 28 || exp_q.size() != 0) && cyc < 600) begin
      in_valid  = (pushes < 28) && ($urandom_range(3, 0) != 0);
      in_sof    = (pushes == 25);
      in_chunk  = rand_chunk();
      row_ready = ($urandom_range(3, 0) != 0);
      step();
      cyc++;
      if (did_push) pushes++;
      if (obs_done) dones++;
      if (did_fire) begin
        if (obs.eof) eofs++;
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL sof_extra_beat: got line=%0d required no beat", obs.line); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin n_fail++; $display("FAIL sof_beat%0d: got line=%0d col=%0d required line=%0d col=%0d", beats, obs.line, obs.col, e.line, e.col); end
        end
        if (beats == 50 || beats == 51) begin
          n_cmp++; if (obs.line !== 10'(beats - 50) || obs.col !== 4'd0) begin n_fail++; $display("FAIL sof_position: got line=%0d col=%0d required line=%0d col=0", obs.line, obs.col, beats - 50); end
        end
        if (beats == 52) begin
          n_cmp++; if (obs.line !== 10'd0 || obs.col !== 4'd1) begin n_fail++; $display("FAIL sof_after: got line=%0d col=%0d required line=0 col=1", obs.line, obs.col); end
        end
        beats++;
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
    n_cmp++; if (eofs !== 0 || dones !== 0) begin n_fail++; $display("FAIL sof_no_eof: got %0d eof %0d done required 0 0", eofs, dones); end
    n_cmp++; if (beats !== 56) begin n_fail++; $display("FAIL sof_beat_count: got %0d required 56", beats); end
  endtask

  task automatic test_reset_midstream();
    int pushes = 0, beats = 0;
    beat_t e;
    do_reset();
    row_ready = 1'b0;
    for (int i = 0; i < 6 && pushes < 2; i++) begin
      in_valid = 1'b1; in_chunk = rand_chunk();
      step();
      if (did_push) pushes++;
    end
    in_valid = 1'b0; row_ready = 1'b1;
    step();
    row_ready = 1'b0;
    n_cmp++; if (!did_fire || pushes !== 2) begin n_fail++; $display("FAIL midreset_setup: got fire=%b pushes=%0d required 1 2", did_fire, pushes); end
    reset = 1'b1; row_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    frame_pos = 0;
    step();
    n_cmp++; if (obs_valid !== 1'b0 || did_fire) begin n_fail++; $display("FAIL midreset_row_valid: got %b required 0", obs_valid); end
    n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b required 1", obs_ready); end
    in_valid = 1'b1; in_chunk = rand_chunk();
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (did_fire) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL midreset_extra_beat: got line=%0d required no beat", obs.line); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin n_fail++; $display("FAIL midreset_beat: got line=%0d col=%0d data=%h required line=%0d col=%0d data=%h", obs.line, obs.col, 64'(obs.data), e.line, e.col, 64'(e.data)); end
        end
        if (beats == 0) begin
          n_cmp++; if (obs.line !== 10'd0 || obs.col !== 4'd0) begin n_fail++; $display("FAIL midreset_start: got line=%0d col=%0d required 0 0", obs.line, obs.col); end
        end
        beats++;
      end
    end
    n_cmp++; if (beats !== 2) begin n_fail++; $display("FAIL midreset_beat_count: got %0d required 2", beats); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; row_ready = 1'b0; in_chunk = '0;
    frame_pos = 0;
    #1;
    test_reset();
    test_single_chunk();
    test_backpressure();
    test_line_wrap();
    test_full_frame();
    test_sof_resync();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
